arbitro_ula: RTL and testbench
==============================

# arbitro_ula

- Two-requester arbiter and sequencer for the shared 8-bit ALU of the 8-bit processor.
- Accepts operation requests (opcode plus two operands) from two independent units, grants the single ALU to one at a time and drives the ALU input ports from registered copies of the winning request.
- Captures the ALU result and zero flag into output registers and returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- LARGURA, 8, data width of operands and result.
- LARG_OP, 3, width of the ALU operation code (`sinal_ula` encoding).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1.
- op0 / op1  in  LARG_OP  ALU opcode for requester 0 / 1.
- a0, b0 / a1, b1  in  LARGURA  operands (entrada1, entrada2) for requester 0 / 1.
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1.
- resultado  out  LARGURA  registered ALU result of the last completed operation.
- zero_out  out  1  registered ALU zero flag of the last completed operation.
- ocupado  out  1  high whenever the FSM is not in IDLE.
- ula_entrada1, ula_entrada2  out  LARGURA  to ALU `entrada1` / `entrada2`.
- ula_sinal  out  LARG_OP  to ALU `sinal_ula`.
- ula_saida  in  LARGURA  from ALU `saida_ula` (combinational).
- ula_zero  in  1  from ALU `zero`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no request, stay.
  - If any request: select the winner, latch its op/a/b into internal registers, record the winner index, go to EXEC.
- EXEC:
  - `ula_*` outputs are driven from the latched registers; the ALU settles combinationally.
  - On the clock edge: capture `ula_saida` into `resultado` and `ula_zero` into `zero_out`, go to RESP.
- RESP:
  - Assert `ack` of the recorded winner only; update `ultimo` (last-granted index) to the winner.
  - Unconditionally go to IDLE.
- `ula_*` outputs always reflect the latched registers and hold their value in IDLE.
- Requester contract:
  - Hold `req` high with operands stable until `ack` is seen.
  - A requester that keeps `req` high in the cycle after `ack` issues a new request.
- `req` dropped during EXEC/RESP: the operation still completes and `ack` still pulses. The arbiter ignores the drop.
- Operand or opcode changes after the IDLE latch cycle have no effect on the current operation.
- Arithmetic: no interpretation of opcodes. The result is exactly the ALU output, truncated to LARGURA. No carry is kept.
- Reset (any state, including mid-operation):
  - FSM returns to IDLE and any pending operation is discarded with no ack.
  - `ack0 = ack1 = 0`, `resultado = 0`, `zero_out = 0`, `ocupado = 0`.
  - Latched op/a/b = 0, so `ula_*` = 0.
  - `ultimo = 1`, so requester 0 wins the first tie.

## Timing
- Request present in IDLE at cycle N → EXEC in N+1 → `ack`, `resultado` and `zero_out` valid in N+2.
- Latency is 2 cycles from sampling to ack. Maximum throughput is 1 operation per 3 cycles.
- `resultado` and `zero_out` hold until the next RESP. They are valid during the ack cycle and every cycle after it.
- `ack0` and `ack1` are never high in the same cycle. Each ack is high for exactly one cycle per granted request.
- `ocupado` is high during EXEC and RESP.
- All outputs are registered except `ula_*`, which come straight from latched state registers.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN`:
  - Defined: tie (req0 and req1 both high in IDLE) goes to the requester other than `ultimo`; a single request wins directly.
  - Not defined: fixed priority, requester 0 always wins ties. `ultimo` is still maintained but does not affect arbitration.
- Starvation: with the macro defined, neither requester can wait more than one operation. With it undefined, requester 1 can starve.

## Test plan
- Single request, AND: req0, a0=4, b0=4, op0=000 → ack0 exactly 2 cycles after sampling, `resultado=4`, `zero_out=0`, ack1 stays 0.
- Zero flag via requester 1, SUB: req1, a1=4, b1=4, op1=011 → ack1 pulse, `resultado=0`, `zero_out=1`. Then ADD 6+31 (op 010) → `resultado=37`, `zero_out=0`.
- Contention, sustained:
  - Setup: req0 and req1 held high continuously, each requester issuing its next request after every ack.
  - With `ARB_ROUND_ROBIN_EN`: acks alternate 0,1,0,1…, one every 3 cycles.
  - Without the macro: only ack0 pulses.
- Operand change mid-op: a0 changed from 6 to 9 during EXEC of ADD 6+31 → `resultado=37`; `ula_entrada1` stays 6 until the next IDLE latch.
- Reset mid-operation: assert reset during EXEC → next cycle FSM is IDLE, no ack is ever issued for that op, `resultado=0`, `zero_out=0`, `ocupado=0`, `ula_*`=0. The first post-reset tie is granted to requester 0.
- Request withdrawn: req0 dropped during EXEC → ack0 still pulses once, `resultado` is updated, and the FSM returns to IDLE with no new grant.

Source files
------------

// File: rtl/arbitro_ula.sv
// -----------------------------------------------------------------------------
// arbitro_ula
//
// Two-requester arbiter and sequencer for the shared 8-bit ALU of the 8-bit
// processor. Each requester presents an opcode and two operands; the arbiter
// grants the ALU to one requester at a time, drives the ALU inputs from
// registered copies of the winning request, captures the ALU result and zero
// flag, and returns a one-cycle acknowledge to the winner.
//
// FSM: IDLE -> EXEC -> RESP -> IDLE (one operation every three cycles at most).
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : a tie goes to the requester that was not
//                                   granted last (round robin).
//                       undefined : fixed priority, requester 0 wins ties.
//
// Parameters:
//   LARGURA   data width of operands and result
//   LARG_OP   width of the ALU operation code (sinal_ula encoding)
//
// Ports:
//   clock          system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   req0 / req1    operation request from requester 0 / 1
//   op0 / op1      ALU opcode of requester 0 / 1
//   a0, b0         operands (entrada1, entrada2) of requester 0
//   a1, b1         operands (entrada1, entrada2) of requester 1
//   ack0 / ack1    one-cycle completion pulse to requester 0 / 1
//   resultado      registered ALU result of the last completed operation
//   zero_out       registered ALU zero flag of the last completed operation
//   ocupado        high whenever the FSM is not in IDLE
//   ula_entrada1   to ALU entrada1 (from latched operand a)
//   ula_entrada2   to ALU entrada2 (from latched operand b)
//   ula_sinal      to ALU sinal_ula (from latched opcode)
//   ula_saida      from ALU saida_ula (combinational)
//   ula_zero       from ALU zero flag
// -----------------------------------------------------------------------------
module arbitro_ula #(
  parameter int LARGURA = 8,
  parameter int LARG_OP = 3
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               req0,
  input  logic [LARG_OP-1:0] op0,
  input  logic [LARGURA-1:0] a0,
  input  logic [LARGURA-1:0] b0,

  input  logic               req1,
  input  logic [LARG_OP-1:0] op1,
  input  logic [LARGURA-1:0] a1,
  input  logic [LARGURA-1:0] b1,

  output logic               ack0,
  output logic               ack1,
  output logic [LARGURA-1:0] resultado,
  output logic               zero_out,
  output logic               ocupado,

  output logic [LARGURA-1:0] ula_entrada1,
  output logic [LARGURA-1:0] ula_entrada2,
  output logic [LARG_OP-1:0] ula_sinal,
  input  logic [LARGURA-1:0] ula_saida,
  input  logic               ula_zero
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         estado;
  logic [1:0]         prox_estado;

  // Latched copy of the granted request; these feed the ALU directly so that
  // requester-side changes after the grant cannot disturb the operation.
  logic [LARG_OP-1:0] op_reg;
  logic [LARGURA-1:0] a_reg;
  logic [LARGURA-1:0] b_reg;

  // Index of the requester currently being served, and of the last one served.
  logic               vencedor;
  logic               ultimo;

  // Combinational arbitration result for the current IDLE cycle.
  logic               algum_req;
  logic               escolha;

  assign algum_req = req0 | req1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block; a path that leaves it unassigned would infer a latch.
`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    escolha = 1'b0;
    if (req0 && req1) begin
      // Tie: serve whoever was not served last.
      escolha = ~ultimo;
    end else begin
      // Single request (or none): req1 alone selects requester 1.
      escolha = req1;
    end
  end
`else
  always_comb begin
    escolha = 1'b0;
    // Fixed priority: requester 1 only wins when requester 0 is silent.
    escolha = ~req0;
  end

  // The last-granted index is still tracked in this build but plays no part
  // in the fixed-priority decision.
  logic unused_ultimo;
  assign unused_ultimo = ultimo;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    prox_estado = IDLE;
    case (estado)
      IDLE:    prox_estado = algum_req ? EXEC : IDLE;
      EXEC:    prox_estado = RESP;
      RESP:    prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, request latch, result capture and acknowledge
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      vencedor  <= 1'b0;
      // Start as if requester 1 was served last, so requester 0 wins the
      // first tie after reset.
      ultimo    <= 1'b1;
      resultado <= '0;
      zero_out  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      estado  <= prox_estado;
      // Registered busy flag tracks the state being entered.
      ocupado <= (prox_estado != IDLE);

      // Acks are single-cycle pulses; only the EXEC branch raises one.
      ack0 <= 1'b0;
      ack1 <= 1'b0;

      case (estado)
        IDLE: begin
          if (algum_req) begin
            vencedor <= escolha;
            if (escolha) begin
              op_reg <= op1;
              a_reg  <= a1;
              b_reg  <= b1;
            end else begin
              op_reg <= op0;
              a_reg  <= a0;
              b_reg  <= b0;
            end
          end
        end

        EXEC: begin
          // The ALU has had the whole EXEC cycle to settle on the latched
          // inputs; capture it and raise the winner's ack for the RESP cycle.
          resultado <= ula_saida;
          zero_out  <= ula_zero;
          ack0      <= ~vencedor;
          ack1      <= vencedor;
        end

        RESP: begin
          ultimo <= vencedor;
        end

        default: begin
        end
      endcase
    end
  end

  // ALU inputs come straight from the latched request and therefore hold
  // their last value while the arbiter is idle.
  assign ula_entrada1 = a_reg;
  assign ula_entrada2 = b_reg;
  assign ula_sinal    = op_reg;

endmodule

// File: tb/tb_arbitro_ula.sv
// -----------------------------------------------------------------------------
// tb_arbitro_ula
//
// Directed bench for arbitro_ula. A small combinational ALU model closes the
// ula_* loop (000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, others pass a).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_arbitro_ula;

  localparam int LARGURA = 8;
  localparam int LARG_OP = 3;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic               req0, req1;
  logic [LARG_OP-1:0] op0, op1;
  logic [LARGURA-1:0] a0, b0, a1, b1;
  logic               ack0, ack1;
  logic [LARGURA-1:0] resultado;
  logic               zero_out;
  logic               ocupado;
  logic [LARGURA-1:0] ula_entrada1, ula_entrada2;
  logic [LARG_OP-1:0] ula_sinal;
  logic [LARGURA-1:0] ula_saida;
  logic               ula_zero;

  int checks = 0;
  int errors = 0;

  arbitro_ula #(
    .LARGURA(LARGURA),
    .LARG_OP(LARG_OP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .op0         (op0),
    .a0          (a0),
    .b0          (b0),
    .req1        (req1),
    .op1         (op1),
    .a1          (a1),
    .b1          (b1),
    .ack0        (ack0),
    .ack1        (ack1),
    .resultado   (resultado),
    .zero_out    (zero_out),
    .ocupado     (ocupado),
    .ula_entrada1(ula_entrada1),
    .ula_entrada2(ula_entrada2),
    .ula_sinal   (ula_sinal),
    .ula_saida   (ula_saida),
    .ula_zero    (ula_zero)
  );

  // Reference ALU standing in for the processor's ALU.
  always_comb begin
    ula_saida = '0;
    case (ula_sinal)
      3'b000:  ula_saida = ula_entrada1 & ula_entrada2;
      3'b001:  ula_saida = ula_entrada1 | ula_entrada2;
      3'b010:  ula_saida = ula_entrada1 + ula_entrada2;
      3'b011:  ula_saida = ula_entrada1 - ula_entrada2;
      3'b100:  ula_saida = ula_entrada1 ^ ula_entrada2;
      default: ula_saida = ula_entrada1;
    endcase
  end
  assign ula_zero = (ula_saida == '0);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic exp1;

    reset = 1'b1;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    step();
    step();

    // Reset state
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_resultado", resultado, 0);
    check("rst_zero", zero_out, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_entrada1", ula_entrada1, 0);
    check("rst_sinal", ula_sinal, 0);
    reset = 1'b0;

    // Single request, AND 4 & 4 from requester 0
    req0 = 1'b1; a0 = 8'd4; b0 = 8'd4; op0 = 3'b000;
    step();                                   // EXEC
    check("and_exec_ocupado", ocupado, 1);
    check("and_exec_ack0", ack0, 0);
    check("and_exec_entrada1", ula_entrada1, 4);
    step();                                   // RESP
    check("and_ack0", ack0, 1);
    check("and_ack1", ack1, 0);
    check("and_resultado", resultado, 4);
    check("and_zero", zero_out, 0);
    req0 = 1'b0;
    step();                                   // IDLE
    check("and_idle_ack0", ack0, 0);
    check("and_idle_ocupado", ocupado, 0);
    check("and_hold_resultado", resultado, 4);

    // Zero flag via requester 1, SUB 4 - 4
    req1 = 1'b1; a1 = 8'd4; b1 = 8'd4; op1 = 3'b011;
    step();
    step();
    check("sub_ack1", ack1, 1);
    check("sub_ack0", ack0, 0);
    check("sub_resultado", resultado, 0);
    check("sub_zero", zero_out, 1);
    req1 = 1'b0;
    step();
    check("sub_idle_ack1", ack1, 0);

    // ADD 6 + 31 via requester 1
    req1 = 1'b1; a1 = 8'd6; b1 = 8'd31; op1 = 3'b010;
    step();
    step();
    check("add1_ack1", ack1, 1);
    check("add1_resultado", resultado, 37);
    check("add1_zero", zero_out, 0);
    req1 = 1'b0;
    step();

    // Operand change during EXEC has no effect
    req0 = 1'b1; a0 = 8'd6; b0 = 8'd31; op0 = 3'b010;
    step();                                   // EXEC
    a0 = 8'd9;
    check("chg_exec_entrada1", ula_entrada1, 6);
    step();                                   // RESP
    check("chg_ack0", ack0, 1);
    check("chg_resultado", resultado, 37);
    check("chg_resp_entrada1", ula_entrada1, 6);
    req0 = 1'b0;
    step();                                   // IDLE
    check("chg_idle_entrada1", ula_entrada1, 6);

    // Request withdrawn during EXEC: OR 0x0F | 0xF0
    req0 = 1'b1; a0 = 8'h0F; b0 = 8'hF0; op0 = 3'b001;
    step();                                   // EXEC
    req0 = 1'b0;
    step();                                   // RESP
    check("wd_ack0", ack0, 1);
    check("wd_resultado", resultado, 8'hFF);
    check("wd_zero", zero_out, 0);
    step();                                   // IDLE
    check("wd_idle_ack0", ack0, 0);
    check("wd_idle_ocupado", ocupado, 0);
    step();                                   // still IDLE, no new grant
    check("wd_nogrant_ocupado", ocupado, 0);
    check("wd_nogrant_ack0", ack0, 0);
    check("wd_hold_entrada2", ula_entrada2, 8'hF0);

    // Reset mid-operation: ADD 3 + 5 discarded
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd5; op0 = 3'b010;
    step();                                   // EXEC
    check("rmid_exec_ocupado", ocupado, 1);
    reset = 1'b1;
    req0 = 1'b0;
    step();
    check("rmid_ocupado", ocupado, 0);
    check("rmid_ack0", ack0, 0);
    check("rmid_resultado", resultado, 0);
    check("rmid_zero", zero_out, 0);
    check("rmid_entrada1", ula_entrada1, 0);
    check("rmid_entrada2", ula_entrada2, 0);
    check("rmid_sinal", ula_sinal, 0);
    reset = 1'b0;
    step();
    check("rmid_after1_ack0", ack0, 0);
    step();
    check("rmid_after2_ack0", ack0, 0);
    check("rmid_after2_ocupado", ocupado, 0);

    // First post-reset tie goes to requester 0 in both builds
    req0 = 1'b1; a0 = 8'd1; b0 = 8'd2; op0 = 3'b010;   // 1 + 2 = 3
    req1 = 1'b1; a1 = 8'd8; b1 = 8'd8; op1 = 3'b000;   // 8 & 8 = 8
    step();
    step();
    check("tie_ack0", ack0, 1);
    check("tie_ack1", ack1, 0);
    check("tie_resultado", resultado, 3);

    // Sustained contention: four more grants
    for (int k = 0; k < 4; k++) begin
      exp1 = RR && (k % 2 == 0);
      step();                                 // IDLE
      check("cont_idle_acks", {ack1, ack0}, 0);
      step();                                 // EXEC
      check("cont_exec_acks", {ack1, ack0}, 0);
      step();                                 // RESP
      check("cont_ack1", ack1, exp1);
      check("cont_ack0", ack0, !exp1);
      check("cont_resultado", resultado, exp1 ? 8 : 3);
    end

    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    check("end_ocupado", ocupado, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
